// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin two-producer arbiter for the FIFO write port with bounded bursts.
// Optional per-producer word and stall counters when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 4,
    parameter int BCNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_b,
    output logic              grant_a,
    output logic              grant_b,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_data
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]       words_a,
    output logic [15:0]       words_b,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_MAX - 1);

    state_t            state, state_nxt;
    logic [BCNT_W-1:0] bcnt, bcnt_nxt;
    logic              last_b, last_b_nxt;

    assign grant_a    = (state == GNT_A);
    assign grant_b    = (state == GNT_B);
    assign ack_a      = grant_a & req_a & ~fifo_full;
    assign ack_b      = grant_b & req_b & ~fifo_full;
    assign fifo_wr_en = ack_a | ack_b;
    assign fifo_data  = grant_b ? data_b : data_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bcnt   <= '0;
            last_b <= 1'b1;
        end else begin
            state  <= state_nxt;
            bcnt   <= bcnt_nxt;
            last_b <= last_b_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        bcnt_nxt   = bcnt;
        last_b_nxt = last_b;
        case (state)
            IDLE: begin
                // On a tie, the producer that did not hold the port last wins.
                if (req_a && (!req_b || last_b)) begin
                    state_nxt  = GNT_A;
                    bcnt_nxt   = '0;
                    last_b_nxt = 1'b0;
                end else if (req_b) begin
                    state_nxt  = GNT_B;
                    bcnt_nxt   = '0;
                    last_b_nxt = 1'b1;
                end
            end
            GNT_A: begin
                if (!req_a || (ack_a && bcnt == BURST_LAST)) begin
                    bcnt_nxt = '0;
                    if (req_b) begin
                        state_nxt  = GNT_B;
                        last_b_nxt = 1'b1;
                    end else if (!req_a) begin
                        state_nxt = IDLE;
                    end
                end else if (ack_a) begin
                    bcnt_nxt = bcnt + 1'b1;
                end
            end
            GNT_B: begin
                if (!req_b || (ack_b && bcnt == BURST_LAST)) begin
                    bcnt_nxt = '0;
                    if (req_a) begin
                        state_nxt  = GNT_A;
                        last_b_nxt = 1'b0;
                    end else if (!req_b) begin
                        state_nxt = IDLE;
                    end
                end else if (ack_b) begin
                    bcnt_nxt = bcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                bcnt_nxt  = '0;
            end
        endcase
    end

`ifdef FIFO_ARB_STATS_EN
    logic stall;
    assign stall = ((grant_a & req_a) | (grant_b & req_b)) & fifo_full;

    // All three counters saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_a   <= '0;
            words_b   <= '0;
            stall_cnt <= '0;
        end else begin
            if (ack_a && words_a != 16'hFFFF)
                words_a <= words_a + 16'd1;
            if (ack_b && words_b != 16'hFFFF)
                words_b <= words_b + 16'd1;
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with directed producer traffic.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        req_a, req_b, fifo_full;
    logic [15:0] data_a, data_b;
    logic        ack_a, ack_b, grant_a, grant_b, fifo_wr_en;
    logic [15:0] fifo_data;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] words_a, words_b, stall_cnt;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [16:0] exp_q[$];
    bit          ack_a_s, ack_b_s;
    time         last_wr_time;

    fifo_wr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .data_a     (data_a),
        .ack_a      (ack_a),
        .req_b      (req_b),
        .data_b     (data_b),
        .ack_b      (ack_b),
        .grant_a    (grant_a),
        .grant_b    (grant_b),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data)
`ifdef FIFO_ARB_STATS_EN
        ,
        .words_a    (words_a),
        .words_b    (words_b),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        req_a  = (qa.size() != 0);
        data_a = req_a ? qa[0] : 16'hDEAD;
        req_b  = (qb.size() != 0);
        data_b = req_b ? qb[0] : 16'hBEEF;
    endtask

    task automatic push(input bit src_b, input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (src_b) qb.push_back(base + 16'(i));
            else       qa.push_back(base + 16'(i));
        end
    endtask

    task automatic expect_w(input bit src_b, input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({src_b, base + 16'(i)});
    endtask

    task automatic wait_ack(input bit src_b, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(src_b ? ack_b : ack_a) && n < 50);
        chk(name, 32'(n < 50), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || grant_a || grant_b) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 100), 32'd1);
        chk({name, "_exp_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        qa.delete(); qb.delete(); exp_q.delete();
        drive();
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Producer model: pop the word that was acked before the edge, present the next one.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ack_a_s && qa.size() != 0) void'(qa.pop_front());
            if (ack_b_s && qb.size() != 0) void'(qb.pop_front());
            ack_a_s = 1'b0;
            ack_b_s = 1'b0;
            drive();
        end
    end

    // Monitor: every FIFO write must match the head of the expected queue.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            ack_a_s = ack_a;
            ack_b_s = ack_b;
            chk("grant_excl", 32'(grant_a & grant_b), 32'd0);
            if (fifo_wr_en) begin
                last_wr_time = $time;
                chk("one_ack", 32'(ack_a ^ ack_b), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got src=%0d data=%0h expected no write", ack_b, fifo_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_src_data", {15'd0, ack_b, fifo_data}, {15'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        rst = 1'b1;
        fifo_full = 1'b0;
        drive();
        repeat (2) @(negedge clk);
        chk("rst_grants", {30'd0, grant_a, grant_b}, 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_fifo_data", 32'(fifo_data), 32'hDEAD);
        @(posedge clk); #2;
        rst = 1'b0;

        // 1: lone producer A, grant latency and burst renewal without competitor
        @(posedge clk); #2;
        push(0, 16'h1110, 6); expect_w(0, 16'h1110, 6); drive();
        @(negedge clk); chk("t1_req_no_grant", {30'd0, req_a, grant_a}, 32'b10);
        @(negedge clk); chk("t1_grant_ack", {30'd0, grant_a, ack_a}, 32'b11);
        for (int i = 1; i < 6; i++) begin
            @(negedge clk); chk("t1_burst_cont", {30'd0, grant_a, ack_a}, 32'b11);
        end
        wait_idle("t1_idle");

        // 2: both contending from reset, 4-word alternation with no bubble
        do_reset();
        @(posedge clk); #2;
        push(0, 16'hA000, 8); push(1, 16'hB000, 8);
        expect_w(0, 16'hA000, 4); expect_w(1, 16'hB000, 4);
        expect_w(0, 16'hA004, 4); expect_w(1, 16'hB004, 4);
        drive();
        wait_ack(0, "t2_first_ack");
        t0 = $time;
        wait_idle("t2_idle");
        chk("t2_span_cycles", 32'((last_wr_time - t0) / 10 + 1), 32'd16);

        // 3: FIFO full for 5 cycles mid-burst with B waiting
        @(posedge clk); #2;
        push(0, 16'hC000, 6); push(1, 16'hD000, 2);
        expect_w(0, 16'hC000, 4); expect_w(1, 16'hD000, 2); expect_w(0, 16'hC004, 2);
        drive();
        wait_ack(0, "t3_first_ack");
        @(posedge clk); #2;
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_full_hold", {27'd0, grant_a, grant_b, ack_a, fifo_wr_en, req_b}, 32'b10001);
        end
        @(posedge clk); #2;
        fifo_full = 1'b0;
        wait_idle("t3_idle");

        // 4: B drops request after 2 words, back to IDLE, then A granted in 1 cycle
        @(posedge clk); #2;
        push(1, 16'hE000, 2); expect_w(1, 16'hE000, 2); drive();
        wait_ack(1, "t4_first_ack");
        @(negedge clk); chk("t4_second_ack", 32'(ack_b), 32'd1);
        @(negedge clk); chk("t4_req_dropped", {30'd0, grant_b, req_b}, 32'b10);
        @(negedge clk); chk("t4_idle", {30'd0, grant_a, grant_b}, 32'd0);
        @(posedge clk); #2;
        push(0, 16'hF000, 1); expect_w(0, 16'hF000, 1); drive();
        @(negedge clk); chk("t4_req_no_grant", {30'd0, req_a, grant_a}, 32'b10);
        @(negedge clk); chk("t4_grant_ack", {30'd0, grant_a, ack_a}, 32'b11);
        wait_idle("t4_idle_end");

        // 5: async reset between edges mid-burst, then tie goes to A
        @(posedge clk); #2;
        push(0, 16'h5000, 8); expect_w(0, 16'h5000, 3); drive();
        wait_ack(0, "t5_first_ack");
        @(negedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_async_rst", {28'd0, grant_a, grant_b, fifo_wr_en, ack_a}, 32'd0);
        qa.delete(); exp_q.delete();
        ack_a_s = 1'b0; ack_b_s = 1'b0;
        drive();
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        push(0, 16'h6000, 1); push(1, 16'h6001, 1);
        expect_w(0, 16'h6000, 1); expect_w(1, 16'h6001, 1);
        drive();
        wait_idle("t5_tie");

        // 6: 6 A words, 3 B words, 2 stall cycles
        do_reset();
        @(posedge clk); #2;
        push(0, 16'h7000, 6); push(1, 16'h8000, 3);
        expect_w(0, 16'h7000, 4); expect_w(1, 16'h8000, 3); expect_w(0, 16'h7004, 2);
        drive();
        wait_ack(0, "t6_first_ack");
        @(posedge clk); #2;
        fifo_full = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        fifo_full = 1'b0;
        wait_idle("t6_idle");
`ifdef FIFO_ARB_STATS_EN
        chk("t6_words_a", 32'(words_a), 32'd6);
        chk("t6_words_b", 32'(words_b), 32'd3);
        chk("t6_stall_cnt", 32'(stall_cnt), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
